lp_grid_solver: RTL and testbench
=================================

Name: lp_grid_solver

Overview:
- Parametrised two-variable integer linear-program solver. Loads an objective row and NCON constraint rows over a serial handshake, then searches every lattice point of a bounding box one point per cycle.
- Reports the optimum value and its argument, with selectable maximize/minimize mode and an explicit infeasible indication.
- Standalone compute block in the OT lab series, driven by a pattern bench.

Parameters:
- CW, 6, signed coefficient width (in_a1, in_a2).
- BW, 12, signed bound/result width (in_b, out_value, out_x1, out_x2).
- NCON, 6, number of constraint rows per problem (>=1).
- RANGE, 31, default search half-range; box is always clamped to [-RANGE, RANGE] per variable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input row valid; high for exactly NCON+1 consecutive cycles per problem
- in_mode  in  1  sampled on first in_valid cycle: 0 = maximize, 1 = minimize
- in_a1  in  CW  signed: objective c1 (first cycle), row coefficient a1 (later cycles)
- in_a2  in  CW  signed: objective c2 (first cycle), row coefficient a2 (later cycles)
- in_b  in  BW  signed: ignored on first cycle, row bound b (later cycles)
- out_busy  out  1  high from first in_valid cycle through the DONE cycle
- out_valid  out  1  one-cycle result strobe
- out_feasible  out  1  at least one lattice point satisfied all rows
- out_value  out  BW  signed optimum objective, saturated
- out_x1  out  BW  signed argument x1
- out_x2  out  BW  signed argument x2

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; all row, box and best registers clear. Applies asynchronously at any state, including mid-SCAN; no partial result is ever emitted.
- States:
  - IDLE: first in_valid cycle captures c1, c2 and mode, then goes to LOAD.
  - LOAD: captures rows 1..NCON in order.
  - PREP: one cycle; box check and x initialisation.
  - SCAN: one point per cycle.
  - DONE: one cycle, out_valid=1, then back to IDLE.
- Row semantics: a1*x1 + a2*x2 <= b. Products are CW+BW bits; sums and comparisons use full width (CW+BW+1), with no truncation.
- Box: lo1 = lo2 = -RANGE, hi1 = hi2 = RANGE at load start. Unit rows tighten the box during LOAD:
  - (1,0): hi1 = min(hi1, b)
  - (-1,0): lo1 = max(lo1, -b)
  - (0,1): hi2 = min(hi2, b)
  - (0,-1): lo2 = max(lo2, -b)
- Unit rows are also kept as ordinary rows.
- PREP: if lo1>hi1 or lo2>hi2, go directly to DONE with out_feasible=0. Otherwise set x1=lo1, x2=lo2 and go to SCAN.
- SCAN order: x1 is the inner loop (lo1..hi1), x2 the outer loop (lo2..hi2).
  - A point is feasible when all NCON rows hold.
  - The objective is evaluated at full width (CW+BW+1).
  - The best point is replaced only on strict improvement (> for max, < for min), so on ties the first point in scan order wins.
  - Leave SCAN after evaluating (hi1, hi2).
- Latency: if the last in_valid cycle is T, then PREP = T+1, SCAN = T+2..T+1+P with P = (hi1-lo1+1)*(hi2-lo2+1), and out_valid = T+2+P. Infeasible box: out_valid = T+2.
- Outputs are updated only in DONE and held until the next DONE or reset.
  - No feasible point: out_feasible=0 and out_value = out_x1 = out_x2 = 0.
  - out_value saturates to [-2^(BW-1), 2^(BW-1)-1]; out_x1 and out_x2 are exact.
- in_valid while out_busy is high and outside LOAD is ignored. in_valid dropping early in LOAD aborts to IDLE with no out_valid.
- out_valid and a new first in_valid may coincide. The new problem is accepted the cycle after DONE (IDLE), so it must not start before then.

Test Plan:
- Max 3x1+2x2; rows x1<=4, -x1<=0, x2<=5, -x2<=0, x1+x2<=6, 2x1-x2<=6 -> box 5x6, P=30, out_valid at T+32, feasible=1, value=16, (x1,x2)=(4,2).
- Same rows, in_mode=1 -> value=0, (0,0), out_valid at T+32.
- Tie: max x1+x2; rows x1<=3, -x1<=0, x2<=3, -x2<=0, x1+x2<=3, 0<=0 -> value=3, (3,0) (first in scan order).
- Infeasible box: rows x1<=2, -x1<=-5, four 0x1+0x2<=0 rows -> out_valid at T+2, feasible=0, value=0.
- No unit rows (RANGE=31): max x1; rows x1-x2<=0, x1+x2<=10, four 0<=0 rows -> P=3969, out_valid at T+3971, value=5, (5,5).
- Assert rst_n low mid-SCAN, then reload the first problem -> all outputs 0 during reset; second run yields 16 at (4,2) with unchanged latency.

Source files
------------

// File: rtl/lp_grid_solver_if.sv
// Handshake/bus bundle for lp_grid_solver.
//   in_valid/in_mode/in_a1/in_a2/in_b : problem rows, driven by the master
//   out_busy/out_valid/out_feasible/out_value/out_x1/out_x2 : result, driven by the solver
interface lp_grid_solver_if #(
  parameter int unsigned CW = 6,
  parameter int unsigned BW = 12
) ();
  logic                 in_valid;
  logic                 in_mode;
  logic signed [CW-1:0] in_a1;
  logic signed [CW-1:0] in_a2;
  logic signed [BW-1:0] in_b;
  logic                 out_busy;
  logic                 out_valid;
  logic                 out_feasible;
  logic signed [BW-1:0] out_value;
  logic signed [BW-1:0] out_x1;
  logic signed [BW-1:0] out_x2;

  modport master (
    output in_valid, in_mode, in_a1, in_a2, in_b,
    input  out_busy, out_valid, out_feasible, out_value, out_x1, out_x2
  );

  modport slave (
    input  in_valid, in_mode, in_a1, in_a2, in_b,
    output out_busy, out_valid, out_feasible, out_value, out_x1, out_x2
  );
endinterface

// File: rtl/lp_grid_solver.sv
// Two-variable integer LP solver: loads objective + NCON rows (a1*x1 + a2*x2 <= b),
// then exhaustively scans the lattice box one point per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lp_grid_solver_if.slave (row input stream, registered result outputs)
module lp_grid_solver #(
  parameter int unsigned CW    = 6,
  parameter int unsigned BW    = 12,
  parameter int unsigned NCON  = 6,
  parameter int unsigned RANGE = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  lp_grid_solver_if.slave bus
);

  localparam int unsigned PW  = CW + BW;      // product width
  localparam int unsigned SW  = CW + BW + 1;  // sum / compare width
  localparam int unsigned BXW = BW + 1;       // box width (holds -b for b = -2^(BW-1))
  localparam int unsigned RW  = (NCON > 1) ? $clog2(NCON) : 1;

  localparam logic signed [BXW-1:0] BOX_HI  = BXW'(RANGE);
  localparam logic signed [BXW-1:0] BOX_LO  = -BOX_HI;
  localparam logic signed [SW-1:0]  SAT_MAX = SW'((1 << (BW - 1)) - 1);
  localparam logic signed [SW-1:0]  SAT_MIN = -SAT_MAX - SW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PREP, S_SCAN, S_DONE} state_t;

  state_t               r_state;
  logic                 r_mode;
  logic signed [CW-1:0] r_c1, r_c2;
  logic signed [CW-1:0] r_a1 [NCON];
  logic signed [CW-1:0] r_a2 [NCON];
  logic signed [BW-1:0] r_b  [NCON];
  logic [RW-1:0]        r_row;
  logic signed [BXW-1:0] r_lo1, r_hi1, r_lo2, r_hi2;
  logic signed [BW-1:0] r_x1, r_x2;
  logic                 r_found;
  logic signed [SW-1:0] r_best;
  logic signed [BW-1:0] r_bx1, r_bx2;

  logic                 r_busy, r_valid, r_feas;
  logic signed [BW-1:0] r_value, r_ox1, r_ox2;

  logic signed [SW-1:0]  w_obj, w_nbest;
  logic                  w_feas, w_take, w_nfound, w_x1_end, w_last;
  logic signed [BW-1:0]  w_nbx1, w_nbx2, w_sat;
  logic signed [BXW-1:0] w_b_ext, w_b_neg;

  // Exact a*x + b*y at SW bits.
  function automatic logic signed [SW-1:0] dot(
    input logic signed [CW-1:0] ca, input logic signed [CW-1:0] cb,
    input logic signed [BW-1:0] xa, input logic signed [BW-1:0] xb);
    logic signed [PW-1:0] p1, p2;
    p1 = PW'(ca) * PW'(xa);
    p2 = PW'(cb) * PW'(xb);
    return SW'(p1) + SW'(p2);
  endfunction

  // Evaluate the current scan point and the candidate best-so-far.
  always_comb begin
    w_obj  = dot(r_c1, r_c2, r_x1, r_x2);
    w_feas = 1'b1;
    for (int i = 0; i < int'(NCON); i++) begin
      if (dot(r_a1[i], r_a2[i], r_x1, r_x2) > SW'(r_b[i])) w_feas = 1'b0;
    end
    // Strict improvement only, so ties keep the earliest point in scan order.
    w_take   = w_feas && (!r_found || (r_mode ? (w_obj < r_best) : (w_obj > r_best)));
    w_nfound = r_found | w_take;
    w_nbest  = w_take ? w_obj : r_best;
    w_nbx1   = w_take ? r_x1  : r_bx1;
    w_nbx2   = w_take ? r_x2  : r_bx2;
    w_x1_end = (BXW'(r_x1) == r_hi1);
    w_last   = w_x1_end && (BXW'(r_x2) == r_hi2);
    if (w_nbest > SAT_MAX)      w_sat = BW'(SAT_MAX);
    else if (w_nbest < SAT_MIN) w_sat = BW'(SAT_MIN);
    else                        w_sat = BW'(w_nbest);
    w_b_ext = BXW'(bus.in_b);
    w_b_neg = -w_b_ext;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_c1    <= '0;
      r_c2    <= '0;
      for (int i = 0; i < int'(NCON); i++) begin
        r_a1[i] <= '0;
        r_a2[i] <= '0;
        r_b[i]  <= '0;
      end
      r_row   <= '0;
      r_lo1   <= '0;
      r_hi1   <= '0;
      r_lo2   <= '0;
      r_hi2   <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_found <= 1'b0;
      r_best  <= '0;
      r_bx1   <= '0;
      r_bx2   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_feas  <= 1'b0;
      r_value <= '0;
      r_ox1   <= '0;
      r_ox2   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mode  <= bus.in_mode;
            r_c1    <= bus.in_a1;
            r_c2    <= bus.in_a2;
            r_lo1   <= BOX_LO;
            r_hi1   <= BOX_HI;
            r_lo2   <= BOX_LO;
            r_hi2   <= BOX_HI;
            r_row   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!bus.in_valid) begin
            // Short row stream: drop the problem silently.
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_a1[r_row] <= bus.in_a1;
            r_a2[r_row] <= bus.in_a2;
            r_b[r_row]  <= bus.in_b;
            // Unit rows also tighten the scan box.
            if (bus.in_a1 == CW'(1) && bus.in_a2 == '0 && w_b_ext < r_hi1)  r_hi1 <= w_b_ext;
            if (bus.in_a1 == CW'(-1) && bus.in_a2 == '0 && w_b_neg > r_lo1) r_lo1 <= w_b_neg;
            if (bus.in_a1 == '0 && bus.in_a2 == CW'(1) && w_b_ext < r_hi2)  r_hi2 <= w_b_ext;
            if (bus.in_a1 == '0 && bus.in_a2 == CW'(-1) && w_b_neg > r_lo2) r_lo2 <= w_b_neg;
            if (r_row == RW'(NCON - 1)) r_state <= S_PREP;
            else                        r_row   <= r_row + RW'(1);
          end
        end
        S_PREP: begin
          r_found <= 1'b0;
          r_best  <= '0;
          r_bx1   <= '0;
          r_bx2   <= '0;
          if (r_lo1 > r_hi1 || r_lo2 > r_hi2) begin
            r_valid <= 1'b1;
            r_feas  <= 1'b0;
            r_value <= '0;
            r_ox1   <= '0;
            r_ox2   <= '0;
            r_state <= S_DONE;
          end else begin
            r_x1    <= BW'(r_lo1);
            r_x2    <= BW'(r_lo2);
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_found <= w_nfound;
          r_best  <= w_nbest;
          r_bx1   <= w_nbx1;
          r_bx2   <= w_nbx2;
          if (w_last) begin
            // Publish including the last point's contribution.
            r_valid <= 1'b1;
            r_feas  <= w_nfound;
            r_value <= w_nfound ? w_sat  : '0;
            r_ox1   <= w_nfound ? w_nbx1 : '0;
            r_ox2   <= w_nfound ? w_nbx2 : '0;
            r_state <= S_DONE;
          end else if (w_x1_end) begin
            r_x1 <= BW'(r_lo1);
            r_x2 <= r_x2 + BW'(1);
          end else begin
            r_x1 <= r_x1 + BW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_busy     = r_busy;
  assign bus.out_valid    = r_valid;
  assign bus.out_feasible = r_feas;
  assign bus.out_value    = r_value;
  assign bus.out_x1       = r_ox1;
  assign bus.out_x2       = r_ox2;

endmodule

// File: tb/tb_lp_grid_solver.sv
// Directed bench for lp_grid_solver: hand-computed optimum, argument and latency per problem.
module tb_lp_grid_solver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ra1 [6];
  int   ra2 [6];
  int   rb  [6];

  always #5 clk = ~clk;

  lp_grid_solver_if #(.CW(6), .BW(12)) bus ();

  lp_grid_solver #(.CW(6), .BW(12), .NCON(6), .RANGE(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Objective cycle followed by nrows row cycles; returns 1 cycle after the last in_valid.
  task automatic load(input logic mode, input int c1, input int c2, input int nrows);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_a1    = 6'(c1);
    bus.in_a2    = 6'(c2);
    bus.in_b     = '0;
    for (int i = 0; i < nrows; i++) begin
      @(posedge clk); #1;
      bus.in_mode = 1'b0;
      bus.in_a1   = 6'(ra1[i]);
      bus.in_a2   = 6'(ra2[i]);
      bus.in_b    = 12'(rb[i]);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a1    = '0;
    bus.in_a2    = '0;
    bus.in_b     = '0;
  endtask

  // Cycle offset from the last in_valid cycle to out_valid, -1 if it never comes.
  task automatic wait_result(output int lat);
    int  n;
    logic seen;
    n    = 1;
    seen = 1'b0;
    lat  = -1;
    while (!seen && n <= 5000) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
  endtask

  task automatic run(input string tag, input logic mode, input int c1, input int c2,
                     input int e_lat, input int e_feas, input int e_val,
                     input int e_x1, input int e_x2);
    int lat;
    load(mode, c1, c2, 6);
    check({tag, "_busy_run"}, int'(bus.out_busy), 1);
    wait_result(lat);
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_feasible"}, int'(bus.out_feasible), e_feas);
    check({tag, "_value"}, int'(bus.out_value), e_val);
    check({tag, "_x1"}, int'(bus.out_x1), e_x1);
    check({tag, "_x2"}, int'(bus.out_x2), e_x2);
    check({tag, "_busy_done"}, int'(bus.out_busy), 1);
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, int'(bus.out_valid), 0);
    check({tag, "_busy_idle"}, int'(bus.out_busy), 0);
    check({tag, "_value_held"}, int'(bus.out_value), e_val);
  endtask

  task automatic rows_box_lp();
    ra1 = '{1, -1, 0,  0, 1,  2};
    ra2 = '{0,  0, 1, -1, 1, -1};
    rb  = '{4,  0, 5,  0, 6,  6};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(bus.out_busy), 0);
    check({tag, "_valid"}, int'(bus.out_valid), 0);
    check({tag, "_feasible"}, int'(bus.out_feasible), 0);
    check({tag, "_value"}, int'(bus.out_value), 0);
    check({tag, "_x1"}, int'(bus.out_x1), 0);
    check({tag, "_x2"}, int'(bus.out_x2), 0);
  endtask

  initial begin
    int vcount;
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'b0;
    bus.in_a1    = '0;
    bus.in_a2    = '0;
    bus.in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Max 3x1+2x2 on a 5x6 box: 16 at (4,2).
    rows_box_lp();
    run("max", 1'b0, 3, 2, 32, 1, 16, 4, 2);

    // Same rows minimized: 0 at (0,0).
    run("min", 1'b1, 3, 2, 32, 1, 0, 0, 0);

    // Tie on x1+x2=3: first in scan order is (3,0).
    ra1 = '{1, -1, 0,  0, 1, 0};
    ra2 = '{0,  0, 1, -1, 1, 0};
    rb  = '{3,  0, 3,  0, 3, 0};
    run("tie", 1'b0, 1, 1, 18, 1, 3, 3, 0);

    // Short row stream aborts: no result strobe, previous result held.
    load(1'b0, 1, 0, 3);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) vcount++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", vcount, 0);
    check("abort_busy", int'(bus.out_busy), 0);
    check("abort_value_held", int'(bus.out_value), 3);

    // Empty box (x1<=2, x1>=5) resolves in PREP.
    ra1 = '{1, -1, 0, 0, 0, 0};
    ra2 = '{0,  0, 0, 0, 0, 0};
    rb  = '{2, -5, 0, 0, 0, 0};
    run("infeasible", 1'b0, 1, 1, 2, 0, 0, 0, 0);

    // No unit rows: full 63x63 box, max x1 with x1<=x2, x1+x2<=10 -> 5 at (5,5).
    ra1 = '{1,  1, 0, 0, 0, 0};
    ra2 = '{-1, 1, 0, 0, 0, 0};
    rb  = '{0, 10, 0, 0, 0, 0};
    run("fullbox", 1'b0, 1, 0, 3971, 1, 5, 5, 5);

    // Reset in the middle of a scan, then the same problem again.
    rows_box_lp();
    load(1'b0, 3, 2, 6);
    repeat (5) @(posedge clk);
    #1;
    check("midscan_busy", int'(bus.out_busy), 1);
    check("midscan_value_held", int'(bus.out_value), 5);
    rst_n = 1'b0;
    #2;
    check_all_zero("midscan_reset");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("midscan_reset_hold");
    rst_n = 1'b1;
    run("rerun", 1'b0, 3, 2, 32, 1, 16, 4, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
